// File: rtl/entropy_scheduler.sv
// Streams the Y/Cb/Cr blocks of every MCU from the block buffers to the entropy coder,
// two coefficients per beat. Define ENTROPY_SCHED_ABORT_EN to add the abort input.
module entropy_scheduler #(
    parameter int Y_BLOCKS = 4  // luma blocks per MCU: 1, 2 or 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      mcu_total,
    output logic             busy,
    output logic             frame_done,
    input  logic [2:0]       blk_avail,
    output logic [2:0]       blk_done,
    output logic             rd_en,
    output logic [1:0]       rd_comp,
    output logic [4:0]       rd_addr,
    input  logic [21:0]      rd_data,
    output logic [1:0][10:0] q,
    output logic             q_valid,
    input  logic             q_hold,
    output logic [4:0]       q_cnt,
    output logic [1:0]       q_chroma,
    output logic             q_last_mcu
`ifdef ENTROPY_SCHED_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_FLUSH} state_t;

    typedef struct packed {
        logic [21:0] data;
        logic [4:0]  cnt;
        logic [1:0]  comp;
        logic        last;
    } beat_t;

    state_t      state, state_nxt;
    logic [2:0]  blk_idx;
    logic [1:0]  comp;
    logic [15:0] mcu_total_r;
    logic [15:0] mcu_cnt;
    logic        last_mcu;
    logic [4:0]  addr;
    logic        in_flight;
    logic [4:0]  fl_cnt;
    logic [1:0]  fl_comp;
    logic        fl_last;
    beat_t       fifo [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  occ;
    beat_t       head;
    logic        pop;
    logic        abort_req;
    logic        start_ok;
    logic        block_end;
    logic        frame_end;
    logic        aborting;

`ifdef ENTROPY_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        if (blk_idx < 3'(Y_BLOCKS))       comp = 2'd0;
        else if (blk_idx == 3'(Y_BLOCKS)) comp = 2'd1;
        else                              comp = 2'd2;
    end

    assign last_mcu = (mcu_cnt == mcu_total_r - 16'd1);
    assign start_ok = (state == S_IDLE) && start && (mcu_total != 16'd0) && !abort_req;

    assign q_valid = (occ != 2'd0);
    assign head    = fifo[rd_ptr];
    assign pop     = q_valid && !q_hold;

    // Outputs are forced to zero when the FIFO is empty so stale storage never shows.
    assign q          = q_valid ? head.data : '0;
    assign q_cnt      = q_valid ? head.cnt  : '0;
    assign q_chroma   = q_valid ? head.comp : '0;
    assign q_last_mcu = q_valid && head.last;

    assign busy    = (state != S_IDLE);
    assign rd_comp = comp;
    assign rd_addr = addr;

    // A read is allowed only if its beat is guaranteed a FIFO slot on arrival.
    assign rd_en = (state == S_STREAM) && !abort_req &&
                   (({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        block_end = 1'b0;
        frame_end = 1'b0;
        aborting  = 1'b0;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_WAIT;
            S_WAIT:   if (blk_avail[comp]) state_nxt = S_STREAM;
            S_STREAM: if (rd_en && addr == 5'd31) state_nxt = S_FLUSH;
            S_FLUSH: begin
                if (pop && head.cnt == 5'd31) begin
                    block_end = 1'b1;
                    if (comp == 2'd2 && last_mcu) begin
                        frame_end = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_req && state != S_IDLE) begin
            aborting  = 1'b1;
            block_end = (state == S_STREAM) || (state == S_FLUSH);
            frame_end = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_done    <= '0;
            frame_done  <= 1'b0;
            blk_idx     <= '0;
            mcu_cnt     <= '0;
            mcu_total_r <= '0;
            addr        <= '0;
            in_flight   <= 1'b0;
            fl_cnt      <= '0;
            fl_comp     <= '0;
            fl_last     <= 1'b0;
            occ         <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
        end else begin
            blk_done   <= block_end ? (3'b001 << comp) : 3'b000;
            frame_done <= frame_end;

            if (start_ok) begin
                mcu_total_r <= mcu_total;
                mcu_cnt     <= '0;
                blk_idx     <= '0;
            end else if (aborting) begin
                blk_idx <= '0;
            end else if (block_end) begin
                if (comp == 2'd2) begin
                    blk_idx <= '0;
                    mcu_cnt <= mcu_cnt + 16'd1;
                end else begin
                    blk_idx <= blk_idx + 3'd1;
                end
            end

            if (state != S_STREAM) addr <= '0;
            else if (rd_en)        addr <= addr + 5'd1;

            // Sideband travels with the read so it lines up with rd_data a cycle later.
            in_flight <= rd_en;
            if (rd_en) begin
                fl_cnt  <= addr;
                fl_comp <= comp;
                fl_last <= last_mcu;
            end

            if (aborting) begin
                in_flight <= 1'b0;
                occ       <= '0;
                wr_ptr    <= 1'b0;
                rd_ptr    <= 1'b0;
            end else begin
                if (in_flight) wr_ptr <= ~wr_ptr;
                if (pop)       rd_ptr <= ~rd_ptr;
                occ <= occ + {1'b0, in_flight} - {1'b0, pop};
            end
        end
    end

    // NOTE: FIFO storage has no reset; it is only ever observed through occupancy-qualified reads.
    always_ff @(posedge clk) begin
        if (in_flight && !aborting)
            fifo[wr_ptr] <= '{data: rd_data, cnt: fl_cnt, comp: fl_comp, last: fl_last};
    end

endmodule

// File: tb/tb_entropy_scheduler.sv
// Self-checking bench for entropy_scheduler: buffer model, beat scoreboard, directed frames.
module tb_entropy_scheduler;
    localparam int Y_BLOCKS = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [15:0]      mcu_total = '0;
    logic             busy;
    logic             frame_done;
    logic [2:0]       blk_avail = 3'b111;
    logic [2:0]       blk_done;
    logic             rd_en;
    logic [1:0]       rd_comp;
    logic [4:0]       rd_addr;
    logic [21:0]      rd_data = '0;
    logic [1:0][10:0] q;
    logic             q_valid;
    logic             q_hold = 1'b0;
    logic [4:0]       q_cnt;
    logic [1:0]       q_chroma;
    logic             q_last_mcu;
`ifdef ENTROPY_SCHED_ABORT_EN
    logic             abort = 1'b0;
`endif

    always #5 clk = ~clk;

    entropy_scheduler #(.Y_BLOCKS(Y_BLOCKS)) dut (
        .clk(clk), .reset(reset), .start(start), .mcu_total(mcu_total),
        .busy(busy), .frame_done(frame_done), .blk_avail(blk_avail), .blk_done(blk_done),
        .rd_en(rd_en), .rd_comp(rd_comp), .rd_addr(rd_addr), .rd_data(rd_data),
        .q(q), .q_valid(q_valid), .q_hold(q_hold), .q_cnt(q_cnt),
        .q_chroma(q_chroma), .q_last_mcu(q_last_mcu)
`ifdef ENTROPY_SCHED_ABORT_EN
        , .abort(abort)
`endif
    );

    int tests = 0;
    int fails = 0;
    int fid = 0;
    int cyc = 0;
    logic [29:0] exp_q[$];
    int buf_n[3] = '{0, 0, 0};
    logic req_v = 1'b0;
    logic [1:0] req_c = '0;
    logic [4:0] req_a = '0;
    bit hold_rand = 0;
    bit no_rd_window = 0;

    int beats, last_beats, first_last_idx, frames, gap_viol, rd_viol, t_start, t_fd;
    int comp_beats[3];
    int dn[3];
    logic [29:0] first_beat, last_beat, prev_beat;
    bit prev_held = 0;
    bit prev_popped = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Buffer contents: distinct per frame, component, block-within-frame and pair index.
    function automatic logic [21:0] model_data(int f, int c, int n, int a);
        logic [10:0] e, o;
        e = 11'(f * 300 + c * 97 + n * 45 + a * 2);
        o = 11'(-(f * 7 + c * 13 + n * 5 + a * 2 + 1));
        return {o, e};
    endfunction

    function automatic logic [63:0] outs();
        return 64'({busy, frame_done, blk_done, rd_en, rd_comp, rd_addr,
                    q, q_valid, q_cnt, q_chroma, q_last_mcu});
    endfunction

    task automatic build_frame(input int m);
        int n[3] = '{0, 0, 0};
        for (int mi = 0; mi < m; mi++) begin
            for (int b = 0; b < Y_BLOCKS + 2; b++) begin
                int c;
                c = (b < Y_BLOCKS) ? 0 : (b == Y_BLOCKS) ? 1 : 2;
                for (int k = 0; k < 32; k++)
                    exp_q.push_back({model_data(fid, c, n[c], k), 5'(k), 2'(c), 1'(mi == m - 1)});
                n[c]++;
            end
        end
    endtask

    task automatic start_frame(input int m);
        @(posedge clk); #1;
        fid++;
        buf_n = '{0, 0, 0};
        beats = 0; last_beats = 0; first_last_idx = -1; frames = 0; gap_viol = 0; rd_viol = 0;
        comp_beats = '{0, 0, 0};
        dn = '{0, 0, 0};
        build_frame(m);
        start = 1'b1;
        mcu_total = 16'(m);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int budget);
        int i = 0;
        while (frames == 0 && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        check(name, 64'(frames), 64'd1);
    endtask

    task automatic wait_beat(input string name, input logic [1:0] c, input logic [4:0] k, input int budget);
        int i = 0;
        bit found = 0;
        while (!found && i < budget) begin
            @(negedge clk); #1;
            found = q_valid && q_chroma == c && q_cnt == k;
            i++;
        end
        check(name, 64'(found), 64'd1);
    endtask

    // Block buffer read port: one cycle latency.
    always @(negedge clk) begin
        req_v = rd_en;
        req_c = rd_comp;
        req_a = rd_addr;
    end

    always @(posedge clk) begin
        #1;
        if (req_v) rd_data = model_data(fid, int'(req_c), buf_n[req_c], int'(req_a));
        q_hold = hold_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Scoreboard and event counters.
    always @(negedge clk) begin
        logic [29:0] beat;
        logic popped;
        cyc++;
        if (reset) begin
            prev_held = 0;
            prev_popped = 0;
        end else begin
            beat = {q, q_cnt, q_chroma, q_last_mcu};
            popped = q_valid && !q_hold;
            if (start && !busy && mcu_total != 16'd0) t_start = cyc;
            if (frame_done) begin
                frames++;
                t_fd = cyc;
            end
            for (int c = 0; c < 3; c++)
                if (blk_done[c]) begin
                    dn[c]++;
                    buf_n[c]++;
                end
            if (no_rd_window && rd_en) rd_viol++;
            if (prev_held) check("hold_stable", 64'({q_valid, beat}), 64'({1'b1, prev_beat}));
            if (q_valid) begin
                if (exp_q.size() == 0) check("beat_extra", 64'(exp_q.size()), 64'd1);
                else check("beat", 64'(beat), 64'(exp_q[0]));
                if (popped) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    if (beats == 0) first_beat = beat;
                    last_beat = beat;
                    if (q_last_mcu && first_last_idx < 0) first_last_idx = beats;
                    comp_beats[q_chroma]++;
                    if (q_last_mcu) last_beats++;
                    if (q_cnt != 5'd0 && !prev_popped) gap_viol++;
                    beats++;
                end
            end
            prev_held = q_valid && q_hold;
            prev_beat = beat;
            prev_popped = popped;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dsum;
        int fr;

        // Reset state, during and after reset.
        #12;
        check("reset_outs", outs(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check("post_reset_outs", outs(), 64'd0);

        // One MCU, no backpressure.
        start_frame(1);
        wait_frame("t1_frame_done", 1000);
        check("t1_beats", 64'(beats), 64'd192);
        check("t1_y_beats", 64'(comp_beats[0]), 64'd128);
        check("t1_cb_beats", 64'(comp_beats[1]), 64'd32);
        check("t1_cr_beats", 64'(comp_beats[2]), 64'd32);
        check("t1_last_beats", 64'(last_beats), 64'd192);
        check("t1_blk_done", 64'(dn[0] * 10000 + dn[1] * 100 + dn[2]), 64'd40101);
        check("t1_latency", 64'(t_fd - t_start), 64'd211);
        check("t1_gaps", 64'(gap_viol), 64'd0);
        check("t1_first_q", 64'(first_beat[29:8]), 64'({11'h7F8, 11'h12C}));
        check("t1_last_beat", 64'(last_beat), 64'({11'h7A0, 11'h22C, 5'd31, 2'd2, 1'b1}));
        check("t1_drained", 64'(exp_q.size()), 64'd0);
        check("t1_busy_low", 64'(busy), 64'd0);

        // Start with zero MCUs is ignored.
        @(posedge clk); #1;
        start = 1'b1;
        mcu_total = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("zero_start_idle", outs(), 64'd0);

        // Two MCUs with random backpressure; a start while busy is ignored.
        start_frame(2);
        hold_rand = 1;
        repeat (50) @(posedge clk);
        #1;
        start = 1'b1;
        mcu_total = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("t2_busy_kept", 64'(busy), 64'd1);
        wait_frame("t2_frame_done", 5000);
        hold_rand = 0;
        check("t2_beats", 64'(beats), 64'd384);
        check("t2_last_beats", 64'(last_beats), 64'd192);
        check("t2_first_last", 64'(first_last_idx), 64'd192);
        check("t2_blk_done", 64'(dn[0] * 10000 + dn[1] * 100 + dn[2]), 64'd80202);
        check("t2_drained", 64'(exp_q.size()), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        check("t2_single_frame_done", 64'(frames), 64'd1);

        // Cb buffer not ready: scheduler waits without reading.
        blk_avail = 3'b101;
        start_frame(1);
        begin
            int i = 0;
            while (dn[0] < 4 && i < 1000) begin
                @(negedge clk); #1;
                i++;
            end
            check("t3_y_done", 64'(dn[0]), 64'd4);
        end
        no_rd_window = 1;
        repeat (100) @(negedge clk);
        #1;
        no_rd_window = 0;
        check("t3_no_reads", 64'(rd_viol), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        blk_avail = 3'b111;
        @(negedge clk); #1;
        check("t3_rd_not_yet", 64'(rd_en), 64'd0);
        @(negedge clk); #1;
        check("t3_cb_first_rd", 64'({rd_en, rd_comp, rd_addr}), 64'({1'b1, 2'd1, 5'd0}));
        wait_frame("t3_frame_done", 1000);
        check("t3_beats", 64'(beats), 64'd192);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a block.
        start_frame(1);
        wait_beat("t5_reach_17", 2'd0, 5'd17, 500);
        reset = 1'b1;
        #1;
        check("t5_reset_outs", outs(), 64'd0);
        exp_q.delete();
        dsum = dn[0] + dn[1] + dn[2];
        fr = frames;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("t5_no_pulses", 64'((dn[0] + dn[1] + dn[2] - dsum) * 100 + frames - fr), 64'd0);
        check("t5_idle", outs(), 64'd0);
        start_frame(1);
        wait_frame("t5_restart_done", 1000);
        check("t5_restart_first", 64'(first_beat[7:0]), 64'({5'd0, 2'd0, 1'b1}));
        check("t5_beats", 64'(beats), 64'd192);
        check("t5_drained", 64'(exp_q.size()), 64'd0);

`ifdef ENTROPY_SCHED_ABORT_EN
        // Abort during the Cb block.
        start_frame(1);
        wait_beat("t6_reach_cb5", 2'd1, 5'd5, 1000);
        abort = 1'b1;
        @(negedge clk); #1;
        check("t6_abort", 64'({q_valid, blk_done, frame_done, busy}), 64'({1'b0, 3'b010, 1'b1, 1'b0}));
        abort = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        #1;
        check("t6_idle", outs(), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/entropy_scheduler.md
# entropy_scheduler

Sequences quantized 8x8 blocks from the three per-component block buffers (Y, Cb, Cr) into the entropy coder, two coefficients per beat. Walks the MCU order (Y_BLOCKS luma blocks, then Cb, then Cr), reads each buffer through a 1-cycle-latency read port, absorbs entropy-side backpressure in a 2-entry skid FIFO, and generates the q_cnt, q_chroma and q_last_mcu sideband the entropy coder needs for DC prediction and end-of-frame reset. Sits between the quantizer block buffers and the entropy coder in the JPEG encoder.

## Interface
Parameters:
- Y_BLOCKS, 4, luma blocks per MCU (4 = 4:2:0, 2 = 4:2:2, 1 = 4:4:4); legal values 1, 2, 4.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  frame start pulse
- mcu_total  in  16  MCUs in frame, sampled on accepted start
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last beat of frame accepted
- blk_avail  in  3  per-buffer full block ready (bit0 Y, bit1 Cb, bit2 Cr)
- blk_done  out  3  one-cycle pulse releasing a buffer
- rd_en  out  1  buffer read strobe
- rd_comp  out  2  buffer select (0 Y, 1 Cb, 2 Cr)
- rd_addr  out  5  coefficient-pair index 0..31 (zig-zag order)
- rd_data  in  22  {coef[2n+1], coef[2n]}, signed 11-bit each, valid cycle after rd_en
- q  out  2x11  signed coefficient pair, q[0] = even coefficient
- q_valid  out  1  beat valid
- q_hold  in  1  entropy coder backpressure
- q_cnt  out  5  pair index of current beat
- q_chroma  out  2  component of current beat (0 Y, 1 Cb, 2 Cr)
- q_last_mcu  out  1  beat belongs to the final MCU of the frame

## Operation
- States: IDLE, WAIT, STREAM, FLUSH.
- IDLE: start & mcu_total != 0 -> latch mcu_total, mcu_cnt=0, blk_idx=0, busy=1, -> WAIT. start with mcu_total==0 ignored; start while busy ignored.
- blk_idx 0..Y_BLOCKS-1 -> comp 0; Y_BLOCKS -> comp 1; Y_BLOCKS+1 -> comp 2.
- WAIT: blk_avail[comp] -> STREAM, rd_addr=0. Other bits ignored.
- STREAM: rd_en issued when occupancy + in_flight - pop < 2 (pop = q_valid & !q_hold). rd_addr increments per read; after read of addr 31 -> FLUSH.
- FLUSH: on pop with q_cnt==31 -> blk_done[comp] pulse, advance blk_idx. After Cr: blk_idx=0, mcu_cnt++; if mcu_cnt was mcu_total-1 -> frame_done pulse, busy=0, -> IDLE; else -> WAIT.
- Sideband (q_cnt, q_chroma, q_last_mcu) stored per FIFO entry with data; q_last_mcu = (mcu_cnt == mcu_total-1) at read issue.
- Beat transfers on q_valid & !q_hold. While held, q and sideband stable. blk_avail deassertion mid-block ignored; buffer must hold contents until blk_done.
- Never more than 2 beats buffered plus in flight; FIFO never overflows, no data dropped.

## Timing
- Reset (async, any state): all outputs 0, FIFO empty, state IDLE; no blk_done/frame_done for interrupted block.
- Read latency: rd_en at cycle t, rd_data captured t+1, q_valid earliest t+2.
- WAIT->first rd_en: 1 cycle after blk_avail[comp] seen.
- Sustained throughput 1 beat/clock with q_hold=0; 32 beats per block.
- Block-to-block gap: blk_done at cycle of final pop +1; next block's first rd_en no earlier than 1 cycle after blk_done.
- q_hold asserted: reads stop within 1 cycle; at most 2 beats buffered; resume at 1 beat/clock on release.
- frame_done coincides with the last blk_done[2]; busy falls same edge.

## Configuration
- ENTROPY_SCHED_ABORT_EN defined: adds input abort (1 bit). On abort while busy: stop reads, discard FIFO and in-flight data, q_valid=0 next cycle, pulse blk_done[comp] if in STREAM/FLUSH, pulse frame_done, -> IDLE. abort in IDLE ignored; abort wins over simultaneous start.
- Not defined: no abort port; frames end only by completion or reset.

## Test plan
- Y_BLOCKS=4, mcu_total=1, all blk_avail=1, q_hold=0 -> 192 beats, q_chroma 0x128/1x32/2x32, q_cnt 0..31 per block, q_last_mcu=1 throughout, six blk_done pulses, frame_done once.
- mcu_total=2, q_hold random 50% -> all 384 beats delivered in order, q stable while held, q_last_mcu=1 only on beats 192..383.
- blk_avail[1]=0 for 100 cycles after Y blocks -> scheduler idles in WAIT, no rd_en, resumes Cb on assertion.
- start with mcu_total=0, and start while busy -> ignored, busy unchanged.
- reset asserted mid-block (q_cnt=17) -> all outputs 0 immediately; new start restarts at Y block 0, q_cnt=0.
- With ENTROPY_SCHED_ABORT_EN: abort at q_cnt=5 of Cb -> q_valid 0 next cycle, blk_done=3'b010 pulse, frame_done pulse, busy=0.
